// File: rtl/bcd_conv_sched_pkg.sv
// bcd_sched_pkg: FSM encoding, digit constants and id-width helper shared by bcd_conv_sched
package bcd_sched_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd4;
    localparam logic [DIGIT_W-1:0] ADJ_ADD = 4'd3;
    function automatic int id_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bcd_conv_sched_if.sv
// bcd_conv_sched_if: requester handshake and tagged BCD result bus
interface bcd_conv_sched_if
    import bcd_sched_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
);
    localparam int ID_W = id_w(N_REQ);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    busy;
    logic [DIGIT_W*DIGITS-1:0] bcd_out;
    logic [ID_W-1:0]         done_id;
    logic                    done_valid;
    logic                    ovf;
    modport master (output req, req_data, input ack, busy, bcd_out, done_id, done_valid, ovf);
    modport slave  (input req, req_data, output ack, busy, bcd_out, done_id, done_valid, ovf);
endinterface

// File: rtl/bcd_conv_sched_dd_core.sv
// bcd_dd_core: serial shift-add-3 engine, one adjust and one shift cycle per bit; BCD_SAT_EN adds sticky overflow
module bcd_dd_core
    import bcd_sched_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    input  logic [DATA_W-1:0]         operand,
    output logic                      idle,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd
`ifdef BCD_SAT_EN
    ,
    output logic                      ovf
`endif
);
    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    state_t           state;
    logic [SR_W-1:0]  sr, adj;
    logic [CNT_W-1:0] cnt;
    logic             shift_ph;
    assign adj[DATA_W-1:0] = sr[DATA_W-1:0];
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        logic [DIGIT_W-1:0] d;
        assign d = sr[DATA_W+DIGIT_W*g +: DIGIT_W];
        assign adj[DATA_W+DIGIT_W*g +: DIGIT_W] = d > ADJ_THRESH ? d + ADJ_ADD : d;
    end
    assign idle = state == S_IDLE;
    assign done = state == S_DONE;
    assign bcd  = sr[SR_W-1 -: BCD_W];
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            sr       <= '0;
            cnt      <= '0;
            shift_ph <= 1'b0;
`ifdef BCD_SAT_EN
            ovf      <= 1'b0;
`endif
        end else if (state == S_IDLE) begin
            if (start) begin
                state    <= S_CONV;
                sr       <= {{BCD_W{1'b0}}, operand};
                cnt      <= '0;
                shift_ph <= 1'b0;
`ifdef BCD_SAT_EN
                ovf      <= 1'b0;
`endif
            end
        end else if (state == S_CONV) begin
            shift_ph <= ~shift_ph;
            if (!shift_ph) begin
                sr <= adj;
            end else begin
                sr  <= sr << 1;
                cnt <= cnt + 1'b1;
`ifdef BCD_SAT_EN
                ovf <= ovf | sr[SR_W-1];
`endif
                if (cnt == CNT_W'(DATA_W - 1)) state <= S_DONE;
            end
        end else begin
            state <= S_IDLE;
        end
    end
endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin shared binary-to-BCD converter; BCD_SAT_EN saturates overflowing operands to all nines
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    bcd_conv_sched_if.slave bus
);
    localparam int ID_W  = id_w(N_REQ);
    localparam int BCD_W = DIGIT_W * DIGITS;
    logic [ID_W-1:0]   ptr, win, idx, cap_id;
    logic [DATA_W-1:0] operand;
    logic [BCD_W-1:0]  core_bcd;
    logic              start, core_idle, core_done;
`ifdef BCD_SAT_EN
    logic              core_ovf;
`endif
    // descending scan so the lowest offset from ptr is written last and wins
    always_comb begin
        win = ptr;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr) + i) % N_REQ);
            if (bus.req[idx]) win = idx;
        end
    end
    always_comb begin
        operand = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win == ID_W'(i)) operand = bus.req_data[i*DATA_W +: DATA_W];
    end
    assign start = core_idle & |bus.req;
    bcd_dd_core #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_core (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .operand   (operand),
        .idle      (core_idle),
        .done      (core_done),
        .bcd       (core_bcd)
`ifdef BCD_SAT_EN
        ,
        .ovf       (core_ovf)
`endif
    );
`ifndef BCD_SAT_EN
    assign bus.ovf = 1'b0;
`endif
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr            <= '0;
            cap_id         <= '0;
            bus.ack        <= '0;
            bus.busy       <= 1'b0;
            bus.bcd_out    <= '0;
            bus.done_id    <= '0;
            bus.done_valid <= 1'b0;
`ifdef BCD_SAT_EN
            bus.ovf        <= 1'b0;
`endif
        end else begin
            bus.ack        <= start ? N_REQ'(1) << win : '0;
            bus.done_valid <= core_done;
            bus.busy       <= start | (bus.busy & ~bus.done_valid);
            if (start) begin
                ptr    <= win == ID_W'(N_REQ - 1) ? '0 : win + 1'b1;
                cap_id <= win;
            end
            if (core_done) begin
                bus.done_id <= cap_id;
`ifdef BCD_SAT_EN
                bus.bcd_out <= core_ovf ? {DIGITS{4'h9}} : core_bcd;
                bus.ovf     <= core_ovf;
`else
                bus.bcd_out <= core_bcd;
`endif
            end
        end
    end
endmodule
